// File: rtl/serial_sign_mag_decoder.sv
`default_nettype none
// ============================================================================
// Module      : serial_sign_mag_decoder
// Description : Bit-serial decoder that converts a two's- or one's-complement
//               operand into an unsigned magnitude plus a sign bit. One
//               operand bit is processed per clock, LSB first. Every
//               conversion takes exactly W SHIFT cycles, followed by a
//               one-cycle DONE pulse.
// Ports       : clk      - rising-edge clock
//               rst      - asynchronous active-high reset
//               start    - conversion request, sampled only in IDLE
//               mode     - 0: two's complement, 1: one's complement
//               in_data  - W-bit operand, captured together with start
//               busy     - high while bits are being shifted
//               done     - one-cycle pulse, results valid from this cycle
//               mag      - unsigned magnitude
//               sign     - operand MSB
//               neg_zero - one's-complement negative zero was decoded
// Revision    : 1.0 - initial release
// ============================================================================
module serial_sign_mag_decoder #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mode,
    input  logic [W-1:0] in_data,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] mag,
    output logic         sign,
    output logic         neg_zero
);

    localparam int             CW     = $clog2(W);
    localparam logic [CW-1:0]  C_LAST = CW'(W - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;

    logic [W-1:0]  r_op;
    logic          r_md;
    logic          r_s;
    logic [CW-1:0] r_cnt;
    logic          r_seen_one;
    logic [W-1:0]  r_res;

    logic          w_bit;
    logic          w_r;
    logic [W-1:0]  w_res_next;
    logic          w_last;

    // ------------------------------------------------------------------
    // Per-bit decode
    // ------------------------------------------------------------------
    always_comb begin
        w_bit = r_op[r_cnt];
        w_r   = w_bit;
        if (r_md) begin
            // One's complement: a negative operand is simply inverted.
            w_r = r_s ? ~w_bit : w_bit;
        end else if (r_s) begin
            // Two's complement negate: copy bits up to and including the
            // first 1, then invert every bit above it.
            w_r = r_seen_one ? ~w_bit : w_bit;
        end
        // Shifting in from the MSB side puts the bit processed first at
        // bit 0 once all W bits have been shifted in.
        w_res_next = {w_r, r_res[W-1:1]};
        w_last     = (r_cnt == C_LAST);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_next = S_SHIFT;
            S_SHIFT: if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = (r_state == S_SHIFT);
        done = (r_state == S_DONE);
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture, serial shift, result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op       <= '0;
            r_md       <= 1'b0;
            r_s        <= 1'b0;
            r_cnt      <= '0;
            r_seen_one <= 1'b0;
            r_res      <= '0;
            mag        <= '0;
            sign       <= 1'b0;
            neg_zero   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op       <= in_data;
                        r_md       <= mode;
                        r_s        <= in_data[W-1];
                        r_cnt      <= '0;
                        r_seen_one <= 1'b0;
                        r_res      <= '0;
                    end
                end
                S_SHIFT: begin
                    r_res      <= w_res_next;
                    r_cnt      <= r_cnt + 1'b1;
                    r_seen_one <= r_seen_one | w_bit;
                    if (w_last) begin
                        // Results are published only on entry to DONE and
                        // then held until the next conversion completes.
                        mag      <= w_res_next;
                        sign     <= r_s;
                        neg_zero <= r_md & (&r_op);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_sign_mag_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_sign_mag_decoder
// Description : Directed self-checking bench for serial_sign_mag_decoder
//               (W=8). Expected results are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_sign_mag_decoder;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic         mode;
    logic [W-1:0] in_data;
    logic         busy;
    logic         done;
    logic [W-1:0] mag;
    logic         sign;
    logic         neg_zero;

    int           n_checks;
    int           n_fail;
    logic [W-1:0] prev_mag;

    serial_sign_mag_decoder #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .in_data  (in_data),
        .busy     (busy),
        .done     (done),
        .mag      (mag),
        .sign     (sign),
        .neg_zero (neg_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one conversion, checks busy for W cycles, and returns during
    // the DONE cycle after checking the results.
    task automatic run_op(input string tag, input logic md, input logic [W-1:0] d,
                          input logic [W-1:0] e_mag, input logic e_sign,
                          input logic e_nz, input bit poke);
        bit got_busy;
        got_busy = 1'b0;
        start    = 1'b1;
        mode     = md;
        in_data  = d;
        for (int k = 0; k < 4 && !got_busy; k++) begin
            tick();
            got_busy = busy;
        end
        start = 1'b0;
        chk({tag, "_accept"}, {31'd0, busy}, 32'd1);
        for (int i = 0; i < W; i++) begin
            if (i == 0 || i == W - 1) begin
                chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
                chk({tag, "_nodone"}, {31'd0, done}, 32'd0);
                chk({tag, "_maghold"}, {24'd0, mag}, {24'd0, prev_mag});
            end
            if (poke && i == 2) begin
                start   = 1'b1;
                mode    = 1'b1;
                in_data = 8'h01;
            end
            if (poke && i == 5) start = 1'b0;
            tick();
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
        chk({tag, "_mag"}, {24'd0, mag}, {24'd0, e_mag});
        chk({tag, "_sign"}, {31'd0, sign}, {31'd0, e_sign});
        chk({tag, "_negz"}, {31'd0, neg_zero}, {31'd0, e_nz});
        prev_mag = e_mag;
    endtask

    task automatic to_idle(input string tag);
        tick();
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        prev_mag = '0;
        rst      = 1'b1;
        start    = 1'b0;
        mode     = 1'b0;
        in_data  = '0;

        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_mag", {24'd0, mag}, 32'd0);
        chk("rst_sign", {31'd0, sign}, 32'd0);
        chk("rst_negz", {31'd0, neg_zero}, 32'd0);
        rst = 1'b0;
        tick();

        run_op("tw_fb", 1'b0, 8'hFB, 8'h05, 1'b1, 1'b0, 1'b0); to_idle("tw_fb");
        run_op("tw_80", 1'b0, 8'h80, 8'h80, 1'b1, 1'b0, 1'b0); to_idle("tw_80");
        run_op("tw_00", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0); to_idle("tw_00");
        run_op("on_fa", 1'b1, 8'hFA, 8'h05, 1'b1, 1'b0, 1'b0); to_idle("on_fa");
        run_op("on_ff", 1'b1, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0); to_idle("on_ff");
        run_op("on_35", 1'b1, 8'h35, 8'h35, 1'b0, 1'b0, 1'b0); to_idle("on_35");
        run_op("tw_35", 1'b0, 8'h35, 8'h35, 1'b0, 1'b0, 1'b0); to_idle("tw_35");

        // Start re-asserted during SHIFT must be ignored.
        run_op("poke", 1'b0, 8'hFB, 8'h05, 1'b1, 1'b0, 1'b1);
        // Next start issued during the DONE cycle and held: accepted in IDLE.
        run_op("chain", 1'b0, 8'h80, 8'h80, 1'b1, 1'b0, 1'b0); to_idle("chain");
        run_op("pre_rst", 1'b0, 8'hFB, 8'h05, 1'b1, 1'b0, 1'b0); to_idle("pre_rst");

        // Asynchronous reset in the middle of a conversion.
        start   = 1'b1;
        mode    = 1'b0;
        in_data = 8'hFB;
        tick();
        start = 1'b0;
        chk("ar_busy_pre", {31'd0, busy}, 32'd1);
        tick(); tick(); tick();
        #2;
        rst = 1'b1;
        #1;
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_done", {31'd0, done}, 32'd0);
        chk("ar_mag", {24'd0, mag}, 32'd0);
        chk("ar_sign", {31'd0, sign}, 32'd0);
        chk("ar_negz", {31'd0, neg_zero}, 32'd0);
        tick();
        rst = 1'b0;
        prev_mag = '0;
        for (int i = 0; i < W + 3; i++) begin
            chk("ar_no_done", {31'd0, done}, 32'd0);
            tick();
        end
        run_op("post_rst", 1'b0, 8'h81, 8'h7F, 1'b1, 1'b0, 1'b0); to_idle("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
